serial_tx_fifo: RTL and testbench
=================================

Name: serial_tx_fifo

Overview:
- Parametrised successor to the current write-only Serial MMIO sink: a buffered UART transmitter on the dmem bus with a real TX pin.
- Bus writes push bytes into a synchronous FIFO. A framing FSM pops them and shifts out start, data, optional parity and stop bits at a programmable divisor.
- Exposes readable status, divisor and control registers, plus a level interrupt for "all sent".
- Decoded by Mmu through sel_serial.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- DATA_BITS, 8, data bits per frame; range 5..8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- DIV_RESET, 87, reset value of the divisor register (10 MHz / 115200).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- clrn  in  1  asynchronous active-low reset.
- sel  in  1  peripheral selected by Mmu.
- we  in  1  bus write strobe, qualified by sel.
- re  in  1  bus read strobe, qualified by sel; used only for read side effects.
- addr  in  4  byte offset within the peripheral; addr[1:0] is ignored.
- din  in  32  write data.
- dout  out  32  read data; combinational from addr and registers.
- tx  out  1  UART line; registered, idle high.
- irq  out  1  level interrupt; registered.

Behaviour:
- Reset (clrn low, asynchronous):
  - tx=1, irq=0, FSM IDLE, FIFO empty.
  - DIV=DIV_RESET, CTRL=0, OVF=0.
- Register map:
  - 0x0 DATA, W: push din[DATA_BITS-1:0]. Reads return 0.
  - 0x4 STATUS, R: {16'b0, count[7:0], 4'b0, ovf, full, empty, busy}. Writing 1 to bit 3 clears ovf.
  - 0x8 DIV, RW: bits [15:0], bit period in clocks. Stored values below 2 act as 2.
  - 0xC CTRL, RW: bit0 irq_en, bit1 tx_hold. While tx_hold is set, no new frame starts.
  - Any other offset reads 0; writes to it are ignored.
- Push: on an edge with sel & we & addr==0x0.
  - If not full, the byte is enqueued.
  - If full, the byte is dropped and ovf is set (sticky).
- Simultaneous push and pop with the FIFO full: push is accepted and count is unchanged.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START back-to-back when the FIFO is non-empty and tx_hold=0.
- IDLE exit: at an edge where the FIFO is non-empty and tx_hold=0:
  - pop the FIFO, load the shift register, latch DIV into the bit timer;
  - enter START with tx=0 from that edge.
- First-bit latency: the write lands at edge N, and tx falls at edge N+1 when the transmitter is idle.
- Bit timing:
  - Each bit holds tx for exactly the latched divisor D clocks.
  - Data goes LSB first.
  - Parity is the XOR of the data bits for even mode, inverted for odd mode.
  - STOP holds tx=1 for STOP_BITS*D clocks.
- DIV writes mid-frame take effect at the next frame start only.
- busy=1 in every state except IDLE.
- irq is registered: irq = irq_en & empty & ~busy.
- clrn asserted mid-frame: tx returns to 1 immediately and the FIFO contents are discarded.
- tx_hold set mid-frame: the current frame completes, then the FSM waits in IDLE.
- count saturates at FIFO_DEPTH, reported in 8 bits.

Decomposition:
- serial_pkg holds:
  - register offset constants (REG_DATA, REG_STATUS, REG_DIV, REG_CTRL);
  - STATUS/CTRL bit indices;
  - the parity enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, sync_fifo, parametrised by WIDTH and DEPTH:
  - push, pop, dout, full, empty, count;
  - async active-low clrn;
  - full-with-simultaneous push/pop allowed.
- The top holds the register file, FSM and bit timer.

Test Plan:
- Reset then read STATUS: expect 0x00000002 (empty only), DIV=87, tx=1, irq=0.
- DIV=4, write 0x55 at edge N -> tx=0 for edges N+1..N+4; data 1,0,1,0,1,0,1,0 for 4 clocks each; tx=1 for 4 clocks; busy falls at N+41.
- PARITY=2, DIV=2, write 0x03 -> parity bit 1 follows the eight data bits; frame is 22 clocks.
- With tx_hold=1, write 17 bytes -> count=16, full=1, ovf=1; clear tx_hold -> 16 back-to-back frames with no idle gap; write 0x8 to STATUS -> ovf=0.
- CTRL irq_en=1, send one byte -> irq is 0 while busy and rises one edge after busy falls; writing CTRL=0 clears irq next edge.
- Assert clrn mid-DATA with 3 bytes queued -> tx=1 asynchronously, STATUS=0x00000002 after release, no further frames.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and types for the buffered UART transmitter
package serial_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_TX_HOLD = 1;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Divisor values below the minimum would make a zero-length bit; clamp them.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/serial_tx_fifo_if.sv
// rtl/serial_tx_fifo_if.sv - dmem bus slice seen by the serial transmitter
interface serial_tx_fifo_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output sel, output we, output re, output addr, output din, input dout);
    modport slave  (input sel, input we, input re, input addr, input din, output dout);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head of queue and flags are combinational from the registered state.
    always_comb begin
        dout  = mem[rd_ptr];
        full  = (cnt == CW'(DEPTH));
        empty = (cnt == '0);
        count = cnt;
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - buffered UART transmitter with register file, framing FSM and bit timer
module serial_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_RESET  = 87
) (
    input  logic             clock,
    input  logic             clrn,
    serial_tx_fifo_if.slave  bus,
    output logic             tx,
    output logic             irq
);
    import serial_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]          div_reg;
    logic [1:0]           ctrl;
    logic                 ovf;

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic                 tx_nxt;
    logic [16:0]          timer;
    logic [16:0]          timer_nxt;
    logic [15:0]          bit_div;
    logic [15:0]          bit_div_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_nxt;
    logic                 par;
    logic                 par_nxt;
    logic                 launch;
    logic [16:0]          bit_period;
    logic [16:0]          stop_period;
    logic [15:0]          div_now;

    logic                 pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    logic [3:0]           offset;
    logic                 wr_en;
    logic                 push_req;
    logic                 ovf_set;
    logic                 busy;
    logic                 start_ok;
    logic [31:0]          count_wide;
    logic [7:0]           count8;
    logic                 unused_bus;

    assign unused_bus = ^{bus.re, bus.din[31:16], bus.addr[1:0]};

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clrn  (clrn),
        .push  (push_req),
        .din   (bus.din[DATA_BITS-1:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus decode and status terms shared by the register file and the FSM.
    always_comb begin
        offset     = {bus.addr[3:2], 2'b00};
        wr_en      = bus.sel & bus.we;
        push_req   = wr_en & (offset == REG_DATA);
        ovf_set    = push_req & fifo_full & ~pop;
        busy       = (state != IDLE);
        start_ok   = ~fifo_empty & ~ctrl[CTRL_TX_HOLD];
        count_wide = 32'(fifo_count);
        count8     = (count_wide > 32'd255) ? 8'hFF : count_wide[7:0];
    end

    // Read mux; reads have no side effects so this stays purely combinational.
    always_comb begin
        bus.dout = '0;
        case (offset)
            REG_STATUS: bus.dout = {16'b0, count8, 4'b0, ovf, fifo_full, fifo_empty, busy};
            REG_DIV:    bus.dout = {16'b0, div_reg};
            REG_CTRL:   bus.dout = {30'b0, ctrl};
            default:    bus.dout = '0;
        endcase
    end

    // Register file writes, sticky overflow (a new overflow beats a same-edge clear) and the irq level.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            div_reg <= 16'(DIV_RESET);
            ctrl    <= '0;
            ovf     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (offset)
                    REG_DIV:    div_reg <= bus.din[15:0];
                    REG_CTRL:   ctrl    <= bus.din[1:0];
                    REG_STATUS: if (bus.din[STAT_OVF]) ovf <= 1'b0;
                    default:    ;
                endcase
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
            irq <= ctrl[CTRL_IRQ_EN] & fifo_empty & ~busy;
        end
    end

    // Framing FSM state, line and bit-timer registers; the line idles high.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_div <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            timer   <= timer_nxt;
            bit_div <= bit_div_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
        end
    end

    // Next-state logic: each bit lasts bit_div clocks, the timer counts down to zero.
    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx;
        timer_nxt   = timer;
        bit_div_nxt = bit_div;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        pop         = 1'b0;
        launch      = 1'b0;
        div_now     = eff_div(div_reg);
        bit_period  = {1'b0, bit_div} - 17'd1;
        stop_period = 17'(STOP_BITS) * {1'b0, bit_div} - 17'd1;

        case (state)
            IDLE: begin
                launch = start_ok;
            end
            START: begin
                if (timer == '0) begin
                    state_nxt   = DATA;
                    tx_nxt      = shift[0];
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = 3'(DATA_BITS - 1);
                    timer_nxt   = bit_period;
                end else begin
                    timer_nxt = timer - 17'd1;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    if (bit_cnt == '0) begin
                        if (PARITY != int'(PAR_NONE)) begin
                            state_nxt = serial_pkg::PARITY;
                            tx_nxt    = par;
                            timer_nxt = bit_period;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                            timer_nxt = stop_period;
                        end
                    end else begin
                        tx_nxt      = shift[0];
                        shift_nxt   = shift >> 1;
                        bit_cnt_nxt = bit_cnt - 3'd1;
                        timer_nxt   = bit_period;
                    end
                end else begin
                    timer_nxt = timer - 17'd1;
                end
            end
            serial_pkg::PARITY: begin
                if (timer == '0) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                    timer_nxt = stop_period;
                end else begin
                    timer_nxt = timer - 17'd1;
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (start_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - 17'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        // Frame start: the divisor is sampled here so mid-frame DIV writes wait for the next frame.
        if (launch) begin
            pop         = 1'b1;
            state_nxt   = START;
            tx_nxt      = 1'b0;
            shift_nxt   = fifo_dout;
            bit_div_nxt = div_now;
            timer_nxt   = {1'b0, div_now} - 17'd1;
            par_nxt     = (^fifo_dout) ^ (PARITY == int'(PAR_ODD));
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - scoreboard bench: line monitors decode frames against queued expectations
module tb_serial_tx_fifo;

    logic clock = 1'b0;
    logic clrn  = 1'b0;
    always #5 clock = ~clock;

    serial_tx_fifo_if bus0();
    serial_tx_fifo_if bus1();
    logic tx0, tx1, irq0, irq1;

    serial_tx_fifo u_dut0 (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus0.slave),
        .tx    (tx0),
        .irq   (irq0)
    );

    serial_tx_fifo #(.PARITY(2)) u_dut1 (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus1.slave),
        .tx    (tx1),
        .irq   (irq1)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   st0[$];
    int   st1[$];
    int   div_m[2];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic line(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction

    function automatic int eff(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input int k, input logic s, input logic w, input logic r,
                           input logic [3:0] a, input logic [31:0] d);
        if (k == 0) begin
            bus0.sel = s; bus0.we = w; bus0.re = r; bus0.addr = a; bus0.din = d;
        end else begin
            bus1.sel = s; bus1.we = w; bus1.re = r; bus1.addr = a; bus1.din = d;
        end
    endtask

    task automatic bus_write(input int k, input logic [3:0] a, input logic [31:0] d, output int edge_n);
        @(negedge clock);
        set_bus(k, 1'b1, 1'b1, 1'b0, a, d);
        @(posedge clock);
        #1;
        set_bus(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        edge_n = cyc;
    endtask

    task automatic bus_read(input int k, input logic [3:0] a, output logic [31:0] d);
        @(negedge clock);
        set_bus(k, 1'b1, 1'b0, 1'b1, a, 32'h0);
        #1;
        d = (k == 0) ? bus0.dout : bus1.dout;
        set_bus(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, output int edge_n);
        exp_t e;
        bus_write(k, 4'h0, {24'h0, b}, edge_n);
        e.data = b;
        e.div  = eff(div_m[k]);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic wait_idle(input int k, input int limit, output int c);
        logic [31:0] s;
        c = -1;
        for (int i = 0; i < limit; i++) begin
            bus_read(k, 4'h4, s);
            if (s[0] == 1'b0 && s[1] == 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle[%0d]: got timeout after %0d cycles expected idle", k, limit);
        end
    endtask

    // Decodes each frame on line k and compares it sample by sample with the ideal waveform.
    task automatic monitor(input int k);
        exp_t e;
        logic bits[$];
        int   total;
        int   bad;
        bit   abort;
        logic s;
        forever begin
            @(negedge clock);
            if (clrn !== 1'b1) continue;
            if (line(k) !== 1'b0) continue;
            if (k == 0) st0.push_back(cyc); else st1.push_back(cyc);
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL frame[%0d]: got unexpected start at cycle %0d expected idle line", k, cyc);
                while (line(k) === 1'b0 && clrn === 1'b1) @(negedge clock);
                continue;
            end
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
            if (k == 1) bits.push_back(~(^e.data));
            bits.push_back(1'b1);
            total = bits.size() * e.div;
            bad   = -1;
            abort = 1'b0;
            for (int i = 0; i < total; i++) begin
                if (i > 0) @(negedge clock);
                if (clrn !== 1'b1) begin
                    abort = 1'b1;
                    break;
                end
                s = line(k);
                if (s !== bits[i / e.div] && bad < 0) bad = i;
            end
            if (abort) continue;
            n_vec++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL frame[%0d] byte %h div %0d: got wrong line level at sample %0d expected %b",
                         k, e.data, e.div, bad, bits[bad / e.div]);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int n, m, c, bad, dv;

        set_bus(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        clrn = 1'b1;
        div_m[0] = 87;
        div_m[1] = 87;

        // Reset state
        bus_read(0, 4'h4, r); check("reset status", r, 32'h2);
        bus_read(0, 4'h8, r); check("reset div", r, 32'd87);
        bus_read(0, 4'hC, r); check("reset ctrl", r, 32'h0);
        bus_read(0, 4'h0, r); check("data reads zero", r, 32'h0);
        check("reset tx", {31'b0, tx0}, 32'h1);
        check("reset irq", {31'b0, irq0}, 32'h0);
        bus_read(1, 4'h4, r); check("reset status1", r, 32'h2);

        // Single frame timing at DIV=4
        bus_write(0, 4'h8, 32'd4, n);
        div_m[0] = 4;
        st0.delete();
        send_byte(0, 8'h55, n);
        wait_idle(0, 200, c);
        check("busy fall", c, n + 41);
        check("first bit latency", (st0.size() > 0) ? st0[0] : -1, n + 1);

        // Interrupt level around one frame
        bus_write(0, 4'hC, 32'h1, m);
        repeat (2) @(negedge clock);
        check("irq idle empty", {31'b0, irq0}, 32'h1);
        send_byte(0, 8'hA3, n);
        bad = 0;
        while (cyc < n + 41) begin
            @(negedge clock);
            if (cyc >= n + 1 && irq0 !== 1'b0) bad++;
        end
        check("irq low while busy", bad, 0);
        @(negedge clock);
        check("irq after busy falls", {31'b0, irq0}, 32'h1);
        bus_write(0, 4'hC, 32'h0, m);
        while (cyc < m + 1) @(negedge clock);
        check("irq cleared", {31'b0, irq0}, 32'h0);

        // Randomized bytes and divisors, including clamped 0/1
        for (int rnd = 0; rnd < 4; rnd++) begin
            dv = (rnd < 2) ? rnd : $urandom_range(2, 6);
            bus_write(0, 4'h8, dv, n);
            div_m[0] = dv;
            bus_read(0, 4'h8, r); check("div readback", r, dv);
            for (int i = 0; i < 6; i++) begin
                b = 8'($urandom);
                send_byte(0, b, n);
                repeat ($urandom_range(0, 40)) @(negedge clock);
            end
            wait_idle(0, 2000, c);
        end

        // Hold, fill past full, release for back-to-back frames
        bus_write(0, 4'h8, 32'd2, n);
        div_m[0] = 2;
        bus_write(0, 4'hC, 32'h2, n);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) send_byte(0, b, n);
            else bus_write(0, 4'h0, {24'h0, b}, n);
        end
        bus_read(0, 4'h4, r); check("full status", r, 32'h0000100C);
        st0.delete();
        bus_write(0, 4'hC, 32'h0, m);
        wait_idle(0, 1000, c);
        check("drain time", c, m + 1 + 16 * 20);
        check("frame count", st0.size(), 16);
        check("first start after release", (st0.size() > 0) ? st0[0] : -1, m + 1);
        bad = 0;
        for (int i = 1; i < st0.size(); i++) if (st0[i] - st0[i-1] != 20) bad++;
        check("back-to-back gaps", bad, 0);
        bus_read(0, 4'h4, r); check("ovf sticky", r, 32'h0000000A);
        bus_write(0, 4'h4, 32'h8, n);
        bus_read(0, 4'h4, r); check("ovf cleared", r, 32'h2);

        // Reset mid-DATA with bytes still queued
        bus_write(0, 4'h8, 32'd4, n);
        div_m[0] = 4;
        bus_write(0, 4'hC, 32'h2, n);
        send_byte(0, 8'h00, n);
        for (int i = 0; i < 3; i++) send_byte(0, 8'($urandom), n);
        bus_write(0, 4'hC, 32'h0, m);
        while (cyc < m + 10) @(negedge clock);
        check("tx low mid data", {31'b0, tx0}, 32'h0);
        #2;
        clrn = 1'b0;
        q0.delete();
        #1;
        check("tx async reset", {31'b0, tx0}, 32'h1);
        repeat (2) @(negedge clock);
        clrn = 1'b1;
        div_m[0] = 87;
        bus_read(0, 4'h4, r); check("status after reset", r, 32'h2);
        bus_read(0, 4'h8, r); check("div after reset", r, 32'd87);
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (tx0 !== 1'b1) bad++;
        end
        check("no frames after reset", bad, 0);

        // Odd parity instance
        bus_write(1, 4'h8, 32'd2, n);
        div_m[1] = 2;
        st1.delete();
        send_byte(1, 8'h03, n);
        while (cyc < n + 19) @(negedge clock);
        check("parity bit", {31'b0, tx1}, 32'h1);
        wait_idle(1, 200, c);
        check("parity frame length", c, n + 1 + 22);
        check("parity first bit", (st1.size() > 0) ? st1[0] : -1, n + 1);
        bus_write(1, 4'h8, 32'd3, n);
        div_m[1] = 3;
        for (int i = 0; i < 5; i++) begin
            send_byte(1, 8'($urandom), n);
            repeat ($urandom_range(0, 20)) @(negedge clock);
        end
        wait_idle(1, 2000, c);

        repeat (4) @(negedge clock);
        check("scoreboard0 drained", q0.size(), 0);
        check("scoreboard1 drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
